// File: rtl/arb3_capture_if.sv
// rtl/arb3_capture_if.sv - requester, mux and output-stream signals of arb3_capture
interface arb3_capture_if #(
   parameter int WIDTH = 8
);
   logic [2:0]       req_valid;
   logic [2:0]       req_ready;
   logic [1:0]       sel;
   logic [WIDTH-1:0] mux_y;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   modport master (
      input  req_valid, mux_y, out_ready,
      output req_ready, sel, out_valid, out_data
   );

   modport slave (
      output req_valid, mux_y, out_ready,
      input  req_ready, sel, out_valid, out_data
   );
endinterface

// File: rtl/arb3_capture.sv
// rtl/arb3_capture.sv - round-robin 3:1 grant driving the mux select, single-entry capture stage
module arb3_capture #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   arb3_capture_if.master    bus
);
   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state_q, state_d;
   logic [1:0]       last_q, last_d;
   logic [WIDTH-1:0] data_q;

   logic             can_load;
   logic             any_req;
   logic             grant;
   logic [1:0]       cand;
   logic [1:0]       o0, o1, o2;

   // search order starts just after the last granted source
   always_comb begin
      o0 = 2'd0;
      o1 = 2'd1;
      o2 = 2'd2;
      case (last_q)
         2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
         2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
         default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
      endcase
   end

   always_comb begin
      cand    = 2'd0;
      any_req = 1'b1;
      if (bus.req_valid[o0])      cand = o0;
      else if (bus.req_valid[o1]) cand = o1;
      else if (bus.req_valid[o2]) cand = o2;
      else                        any_req = 1'b0;
   end

   always_comb begin
      can_load      = (state_q == EMPTY) | bus.out_ready;
      grant         = can_load & any_req & ~reset;
      bus.req_ready = 3'b000;
      bus.sel       = 2'b00;
      state_d       = state_q;
      last_d        = last_q;
      if (grant) begin
         bus.req_ready = 3'b001 << cand;
         bus.sel       = cand;
         state_d       = FULL;
         last_d        = cand;
      end else if (state_q == FULL && bus.out_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         last_q  <= 2'd2;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         if (grant) data_q <= bus.mux_y;
      end
   end

   assign bus.out_valid = (state_q == FULL);
   assign bus.out_data  = data_q;
endmodule

// File: tb/tb_arb3_capture.sv
// tb/tb_arb3_capture.sv - directed vector bench for arb3_capture
module tb_arb3_capture;
   logic clk = 1'b0;
   logic reset;
   logic [7:0] d0, d1, d2;

   arb3_capture_if #(.WIDTH(8)) bus ();

   arb3_capture #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.mux_y = (bus.sel == 2'b00) ? d0 : (bus.sel == 2'b01) ? d1 : d2;

   typedef struct {
      logic       rst;
      logic [2:0] rv;
      logic       ordy;
      logic [7:0] a0, a1, a2;
      logic [2:0] exp_rr;
      logic [1:0] exp_sel;
      logic       exp_ov;
      logic [7:0] exp_od;
   } vec_t;

   vec_t vecs[$];
   int   applied = 0;
   int   miscompares = 0;

   function automatic void add(logic rst, logic [2:0] rv, logic ordy,
                               logic [7:0] a0, logic [7:0] a1, logic [7:0] a2,
                               logic [2:0] rr, logic [1:0] s, logic ov, logic [7:0] od);
      vec_t v;
      v.rst = rst; v.rv = rv; v.ordy = ordy;
      v.a0 = a0; v.a1 = a1; v.a2 = a2;
      v.exp_rr = rr; v.exp_sel = s; v.exp_ov = ov; v.exp_od = od;
      vecs.push_back(v);
   endfunction

   task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.sel == 2'b11) begin
         miscompares++;
         $display("FAIL sel_never_11: got %0b expected not 11", bus.sel);
      end
   end

   int cnt[3];

   initial begin
      // reset held with all requests pending
      add(1, 3'b111, 1, 8'h0A, 8'h1B, 8'h2C, 3'b000, 2'd0, 0, 8'h00);
      add(1, 3'b111, 1, 8'h0A, 8'h1B, 8'h2C, 3'b000, 2'd0, 0, 8'h00);
      // all three requesting, out_ready=1
      add(0, 3'b111, 1, 8'h0A, 8'h1B, 8'h2C, 3'b001, 2'd0, 1, 8'h0A);
      add(0, 3'b111, 1, 8'h0A, 8'h1B, 8'h2C, 3'b010, 2'd1, 1, 8'h1B);
      add(0, 3'b111, 1, 8'h0A, 8'h1B, 8'h2C, 3'b100, 2'd2, 1, 8'h2C);
      add(0, 3'b111, 1, 8'h0A, 8'h1B, 8'h2C, 3'b001, 2'd0, 1, 8'h0A);
      add(0, 3'b111, 1, 8'h0A, 8'h1B, 8'h2C, 3'b010, 2'd1, 1, 8'h1B);
      add(0, 3'b111, 1, 8'h0A, 8'h1B, 8'h2C, 3'b100, 2'd2, 1, 8'h2C);
      // only source 2
      add(0, 3'b100, 1, 8'h00, 8'h00, 8'h55, 3'b100, 2'd2, 1, 8'h55);
      add(0, 3'b100, 1, 8'h00, 8'h00, 8'h55, 3'b100, 2'd2, 1, 8'h55);
      add(0, 3'b100, 1, 8'h00, 8'h00, 8'h55, 3'b100, 2'd2, 1, 8'h55);
      // drain with no request keeps stale data
      add(0, 3'b000, 1, 8'h00, 8'h00, 8'h55, 3'b000, 2'd0, 0, 8'h55);
      // back-pressure on source 1
      add(0, 3'b010, 0, 8'h00, 8'h33, 8'h00, 3'b010, 2'd1, 1, 8'h33);
      add(0, 3'b010, 0, 8'h00, 8'h33, 8'h00, 3'b000, 2'd0, 1, 8'h33);
      add(0, 3'b010, 0, 8'h00, 8'h33, 8'h00, 3'b000, 2'd0, 1, 8'h33);
      add(0, 3'b010, 1, 8'h00, 8'h44, 8'h00, 3'b010, 2'd1, 1, 8'h44);
      // sources 0 and 2 alternate after a grant to 0
      add(0, 3'b001, 1, 8'hA0, 8'h00, 8'hC2, 3'b001, 2'd0, 1, 8'hA0);
      add(0, 3'b101, 1, 8'hA0, 8'h00, 8'hC2, 3'b100, 2'd2, 1, 8'hC2);
      add(0, 3'b101, 1, 8'hA0, 8'h00, 8'hC2, 3'b001, 2'd0, 1, 8'hA0);
      add(0, 3'b101, 1, 8'hA0, 8'h00, 8'hC2, 3'b100, 2'd2, 1, 8'hC2);
      // reset while FULL with 77 and requests pending
      add(0, 3'b001, 1, 8'h77, 8'h00, 8'h00, 3'b001, 2'd0, 1, 8'h77);
      add(1, 3'b111, 0, 8'h77, 8'h11, 8'h22, 3'b000, 2'd0, 0, 8'h00);
      add(0, 3'b110, 1, 8'h77, 8'h11, 8'h22, 3'b010, 2'd1, 1, 8'h11);
      add(0, 3'b000, 0, 8'h77, 8'h11, 8'h22, 3'b000, 2'd0, 1, 8'h11);
      add(0, 3'b000, 1, 8'h77, 8'h11, 8'h22, 3'b000, 2'd0, 0, 8'h11);

      reset = 1'b1;
      bus.req_valid = 3'b000;
      bus.out_ready = 1'b0;
      d0 = 8'h00; d1 = 8'h00; d2 = 8'h00;
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst;
         bus.req_valid = vecs[i].rv;
         bus.out_ready = vecs[i].ordy;
         d0 = vecs[i].a0; d1 = vecs[i].a1; d2 = vecs[i].a2;
         @(negedge clk);
         applied++;
         cmp("req_ready", i, 32'(bus.req_ready), 32'(vecs[i].exp_rr));
         cmp("sel", i, 32'(bus.sel), 32'(vecs[i].exp_sel));
         @(posedge clk);
         #1;
         cmp("out_valid", i, 32'(bus.out_valid), 32'(vecs[i].exp_ov));
         cmp("out_data", i, 32'(bus.out_data), 32'(vecs[i].exp_od));
      end

      // fairness and full throughput over nine cycles of continuous requests
      for (int k = 0; k < 3; k++) cnt[k] = 0;
      bus.req_valid = 3'b111;
      bus.out_ready = 1'b1;
      d0 = 8'h01; d1 = 8'h02; d2 = 8'h03;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) if (bus.req_ready[k]) cnt[k]++;
         @(posedge clk);
         #1;
      end
      for (int k = 0; k < 3; k++) begin
         applied++;
         cmp("fair_grants", k, 32'(cnt[k]), 32'd3);
      end

      // back-pressure then release: bounded wait for the held word to drain
      bus.req_valid = 3'b000;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      applied++;
      cmp("hold_valid", 0, 32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b1;
      begin
         int budget = 5;
         while (bus.out_valid && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
         end
         applied++;
         cmp("drain_timeout", 0, 32'(bus.out_valid), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule
